// File: rtl/rotate_arbiter.sv
// Two-requester arbiter in front of a shared external rotator: grants one
// request, registers its operands, captures the result and holds it until accepted.
module rotate_arbiter #(
  parameter int unsigned FIXED_PRIO = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [31:0] req_a0,
  input  logic [31:0] req_a1,
  input  logic [4:0]  req_amt0,
  input  logic [4:0]  req_amt1,
  input  logic        req_dir0,
  input  logic        req_dir1,
  output logic [31:0] rot_a,
  output logic [4:0]  rot_amt,
  output logic        rot_dir,
  input  logic [31:0] rot_y,
  output logic [1:0]  rsp_valid,
  output logic [31:0] rsp_y,
  input  logic [1:0]  rsp_ready,
  output logic        busy
);

  localparam logic [1:0] S_IDLE = 2'b00;
  localparam logic [1:0] S_EXEC = 2'b01;
  localparam logic [1:0] S_RESP = 2'b10;

  logic [1:0]  state_q, state_d;
  logic [31:0] rot_a_q, rot_a_d;
  logic [4:0]  rot_amt_q, rot_amt_d;
  logic        rot_dir_q, rot_dir_d;
  logic [31:0] rsp_y_q, rsp_y_d;
  logic        gnt_id_q, gnt_id_d;
  logic        last_grant_q, last_grant_d;

  logic [1:0]  grant;
  logic        handshake;
  logic        rsp_done;

  // Grant is only ever non-zero in IDLE, so req_ready doubles as the handshake.
  always_comb begin
    grant = '0;
    if (state_q == S_IDLE) begin
      if (FIXED_PRIO != 0) begin
        if (req_valid[0]) begin
          grant = 2'b01;
        end else if (req_valid[1]) begin
          grant = 2'b10;
        end
      end else begin
        case (req_valid)
          2'b01:   grant = 2'b01;
          2'b10:   grant = 2'b10;
          2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
          default: grant = '0;
        endcase
      end
    end
  end

  assign handshake = |grant;
  assign rsp_done  = rsp_ready[gnt_id_q];

  always_comb begin
    state_d      = state_q;
    rot_a_d      = rot_a_q;
    rot_amt_d    = rot_amt_q;
    rot_dir_d    = rot_dir_q;
    rsp_y_d      = rsp_y_q;
    gnt_id_d     = gnt_id_q;
    last_grant_d = last_grant_q;
    case (state_q)
      S_IDLE: begin
        if (handshake) begin
          gnt_id_d     = grant[1];
          last_grant_d = grant[1];
          rot_a_d      = grant[1] ? req_a1   : req_a0;
          rot_amt_d    = grant[1] ? req_amt1 : req_amt0;
          rot_dir_d    = grant[1] ? req_dir1 : req_dir0;
          state_d      = S_EXEC;
        end
      end
      S_EXEC: begin
        rsp_y_d = rot_y;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      rot_a_q      <= '0;
      rot_amt_q    <= '0;
      rot_dir_q    <= 1'b0;
      rsp_y_q      <= '0;
      gnt_id_q     <= 1'b0;
      last_grant_q <= 1'b1;
    end else begin
      state_q      <= state_d;
      rot_a_q      <= rot_a_d;
      rot_amt_q    <= rot_amt_d;
      rot_dir_q    <= rot_dir_d;
      rsp_y_q      <= rsp_y_d;
      gnt_id_q     <= gnt_id_d;
      last_grant_q <= last_grant_d;
    end
  end

  assign req_ready = grant;
  assign rsp_valid = (state_q == S_RESP) ? (gnt_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy      = (state_q != S_IDLE);
  assign rot_a     = rot_a_q;
  assign rot_amt   = rot_amt_q;
  assign rot_dir   = rot_dir_q;
  assign rsp_y     = rsp_y_q;

endmodule

// File: tb/tb_rotate_arbiter.sv
// Directed bench: round-robin and fixed-priority instances share stimulus,
// each driving its own behavioural rotator.
module tb_rotate_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  req_valid;
  logic [31:0] req_a0, req_a1;
  logic [4:0]  req_amt0, req_amt1;
  logic        req_dir0, req_dir1;
  logic [1:0]  rsp_ready;

  logic [1:0]  req_ready_r, rsp_valid_r, req_ready_f, rsp_valid_f;
  logic [31:0] rot_a_r, rot_y_r, rsp_y_r, rot_a_f, rot_y_f, rsp_y_f;
  logic [4:0]  rot_amt_r, rot_amt_f;
  logic        rot_dir_r, rot_dir_f, busy_r, busy_f;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rotf(input logic [31:0] a, input logic [4:0] n, input logic d);
    logic [63:0] w;
    if (d) begin
      w = {a, a} >> n;
      return w[31:0];
    end
    w = {a, a} << n;
    return w[63:32];
  endfunction

  assign rot_y_r = rotf(rot_a_r, rot_amt_r, rot_dir_r);
  assign rot_y_f = rotf(rot_a_f, rot_amt_f, rot_dir_f);

  rotate_arbiter #(.FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_r),
    .req_a0(req_a0), .req_a1(req_a1), .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_dir0(req_dir0), .req_dir1(req_dir1), .rot_a(rot_a_r), .rot_amt(rot_amt_r),
    .rot_dir(rot_dir_r), .rot_y(rot_y_r), .rsp_valid(rsp_valid_r), .rsp_y(rsp_y_r),
    .rsp_ready(rsp_ready), .busy(busy_r)
  );

  rotate_arbiter #(.FIXED_PRIO(1)) u_fp (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_f),
    .req_a0(req_a0), .req_a1(req_a1), .req_amt0(req_amt0), .req_amt1(req_amt1),
    .req_dir0(req_dir0), .req_dir1(req_dir1), .rot_a(rot_a_f), .rot_amt(rot_amt_f),
    .rot_dir(rot_dir_f), .rot_y(rot_y_f), .rsp_valid(rsp_valid_f), .rsp_y(rsp_y_f),
    .rsp_ready(rsp_ready), .busy(busy_f)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; req_valid = 2'b00; rsp_ready = 2'b11;
    req_a0 = '0; req_a1 = '0; req_amt0 = '0; req_amt1 = '0; req_dir0 = 1'b0; req_dir1 = 1'b0;
    cyc(); cyc();
    chk("rst_busy", {31'd0, busy_r}, 32'd0);
    chk("rst_req_ready", {30'd0, req_ready_r}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid_r}, 32'd0);
    chk("rst_rsp_y", rsp_y_r, 32'd0);
    chk("rst_rot", {rot_a_r[26:0], rot_amt_r}, 32'd0);
    chk("rst_rot_dir", {31'd0, rot_dir_r}, 32'd0);
    reset = 1'b0;

    // Single operation, handshake at cycle N
    req_valid = 2'b01; req_a0 = 32'h0000_0001; req_amt0 = 5'd1; req_dir0 = 1'b1;
    #1;
    chk("single_req_ready", {30'd0, req_ready_r}, 32'd1);
    chk("single_req_ready_fp", {30'd0, req_ready_f}, 32'd1);
    cyc(); req_valid = 2'b00; #1;
    chk("exec_busy", {31'd0, busy_r}, 32'd1);
    chk("exec_req_ready", {30'd0, req_ready_r}, 32'd0);
    chk("exec_rsp_valid", {30'd0, rsp_valid_r}, 32'd0);
    chk("exec_rot_a", rot_a_r, 32'h0000_0001);
    chk("exec_rot_amt_dir", {26'd0, rot_amt_r, rot_dir_r}, 32'd3);
    cyc();
    chk("single_rsp_valid", {30'd0, rsp_valid_r}, 32'd1);
    chk("single_rsp_y", rsp_y_r, 32'h8000_0000);
    chk("single_rsp_y_fp", rsp_y_f, 32'h8000_0000);
    cyc();
    chk("single_idle", {31'd0, busy_r}, 32'd0);
    chk("single_rsp_clear", {30'd0, rsp_valid_r}, 32'd0);
    chk("single_rsp_y_hold", rsp_y_r, 32'h8000_0000);

    // Contention out of reset
    reset = 1'b1; cyc(); reset = 1'b0;
    req_valid = 2'b11;
    req_a0 = 32'h0000_00F0; req_amt0 = 5'd4; req_dir0 = 1'b0;
    req_a1 = 32'h1234_5678; req_amt1 = 5'd8; req_dir1 = 1'b1;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("cont_grant", {30'd0, req_ready_r}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("fp_grant", {30'd0, req_ready_f}, 32'd1);
      cyc(); cyc();
      chk("cont_rsp_valid", {30'd0, rsp_valid_r}, (k % 2 == 0) ? 32'd1 : 32'd2);
      chk("cont_rsp_y", rsp_y_r, (k % 2 == 0) ? 32'h0000_0F00 : 32'h7812_3456);
      chk("cont_resp_no_accept", {30'd0, req_ready_r}, 32'd0);
      chk("fp_rsp_valid", {30'd0, rsp_valid_f}, 32'd1);
      chk("fp_rsp_y", rsp_y_f, 32'h0000_0F00);
      cyc();
    end
    req_valid = 2'b00;

    // Backpressure on requester 0
    rsp_ready = 2'b00;
    req_valid = 2'b01; req_a0 = 32'h0000_FFFF; req_amt0 = 5'd16; req_dir0 = 1'b0;
    #1;
    chk("bp_grant", {30'd0, req_ready_r}, 32'd1);
    cyc(); req_valid = 2'b11; cyc();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {30'd0, rsp_valid_r}, 32'd1);
      chk("bp_rsp_y", rsp_y_r, 32'hFFFF_0000);
      chk("bp_req_ready", {30'd0, req_ready_r}, 32'd0);
      chk("bp_busy", {31'd0, busy_r}, 32'd1);
      cyc();
    end
    req_valid = 2'b00; rsp_ready = 2'b10;
    cyc();
    chk("bp_other_ready_ignored", {30'd0, rsp_valid_r}, 32'd1);
    rsp_ready = 2'b01;
    cyc();
    chk("bp_idle_after_ready", {31'd0, busy_r}, 32'd0);
    chk("bp_rsp_clear", {30'd0, rsp_valid_r}, 32'd0);
    rsp_ready = 2'b11;

    // Reset during EXEC; last grant was requester 0 before the reset
    req_valid = 2'b01; #1;
    cyc(); req_valid = 2'b00; reset = 1'b1;
    chk("pre_reset_exec", {31'd0, busy_r}, 32'd1);
    cyc();
    chk("midrst_busy", {31'd0, busy_r}, 32'd0);
    chk("midrst_rsp_valid", {30'd0, rsp_valid_r}, 32'd0);
    chk("midrst_rsp_y", rsp_y_r, 32'd0);
    reset = 1'b0;
    cyc();
    chk("midrst_no_rsp", {30'd0, rsp_valid_r}, 32'd0);

    // Boundary amounts, tie after reset goes to requester 0 first
    req_valid = 2'b11;
    req_a0 = 32'hDEAD_BEEF; req_amt0 = 5'd0;  req_dir0 = 1'b1;
    req_a1 = 32'h0000_0001; req_amt1 = 5'd31; req_dir1 = 1'b0;
    #1;
    chk("tie_after_reset", {30'd0, req_ready_r}, 32'd1);
    cyc(); cyc();
    chk("amt0_rsp_valid", {30'd0, rsp_valid_r}, 32'd1);
    chk("amt0_passthru", rsp_y_r, 32'hDEAD_BEEF);
    cyc();
    chk("tie_second", {30'd0, req_ready_r}, 32'd2);
    cyc(); cyc();
    chk("amt31_rsp_valid", {30'd0, rsp_valid_r}, 32'd2);
    chk("amt31_left", rsp_y_r, 32'h8000_0000);
    req_valid = 2'b00;
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule
